flt2int_iter: RTL and testbench
===============================

// Module: flt2int_iter
// PURPOSE
//  Parametrised, iterative IEEE-style float to signed two's-complement integer converter.
//  Generalises the fixed half-precision converter:
//   - configurable exponent, mantissa and integer widths
//   - negative inputs
//   - selectable truncate or round-nearest-even
//   - saturation at both ends, with sat/inexact flags
//  Sits beside the datapath as a req/ack coprocessor; shifts one bit per cycle to save area.
// PARAMETERS
//  EXP_W  5   exponent field width; bias = 2**(EXP_W-1)-1
//  MAN_W  10  stored fraction width (hidden bit restored internally)
//  INT_W  16  result width; must satisfy INT_W >= MAN_W+2
// PORTS
//  clk       in   1              single clock, rising edge
//  reset_n   in   1              asynchronous, active-low reset
//  req       in   1              conversion request, level-sampled in IDLE
//  rnd_mode  in   1              0 = truncate toward zero, 1 = round-nearest-even; captured with flt_in
//  flt_in    in   1+EXP_W+MAN_W  {sign, exponent, fraction}; captured when req accepted
//  busy      out  1              high from acceptance through the ack cycle
//  ack       out  1              one-cycle pulse; int_out/sat/inexact valid from this cycle
//  int_out   out  INT_W          signed result; held until next acceptance
//  sat       out  1              result clamped (overflow, inf, NaN)
//  inexact   out  1              discarded nonzero fraction bits (before rounding)
// BEHAVIOUR
//  Reset: async on reset_n low.
//   - FSM->IDLE; busy=0, ack=0, int_out=0, sat=0, inexact=0.
//   - Any conversion in flight is abandoned; no ack is issued for it.
//  FSM states: IDLE, DECODE, SHIFT, ROUND, DONE.
//   - IDLE:   req=1 at edge -> capture flt_in/rnd_mode, go to DECODE, busy=1.
//   - DECODE: e = exp - bias; sig = {|exp, frac}.
//   - SHIFT:  k cycles, one bit per cycle (k=0 skips to ROUND).
//             e>=MAN_W: shift left, k = e-MAN_W.
//             e<MAN_W:  shift right, k = MAN_W-e; guard = last bit out; sticky = OR of earlier bits out.
//   - ROUND:  rnd_mode=1 adds 1 if guard & (sticky | lsb); then apply sign (two's complement).
//             Clamp: MAX = 2**(INT_W-1)-1, MIN = -2**(INT_W-1); set sat if clamped.
//   - DONE:   ack=1, outputs registered; next edge -> IDLE.
//  Special cases, evaluated in DECODE, go directly to DONE:
//   - exp==0 (zero/subnormal) -> 0. inexact = (frac!=0); sat = 0.
//   - exp all-ones: +inf -> MAX; -inf -> MIN; NaN -> MAX. sat = 1.
//   - e < -1 -> 0. inexact = 1; sat = 0.
//   - e >= INT_W-1 -> MAX for positive, MIN for negative. sat = 1, except an exact
//     -2**(INT_W-1) gives MIN with sat = 0.
//  Latency, from the acceptance edge to the ack cycle:
//   - special cases: 2 cycles.
//   - otherwise: 3+k cycles. Max is MAN_W+4, at e = -1.
//  Handshake:
//   - req is ignored while busy.
//   - req held high through DONE starts a new conversion on the first IDLE cycle
//     (back-to-back throughput = latency+1).
//   - flt_in may change any time after acceptance.
//  Rounding carry out of the MSB (e.g. value rounds up to 2**(INT_W-1)) saturates: sat = 1.
//  -0.0 -> 0, sat = 0, inexact = 0.
// TESTING (defaults; rnd_mode=0 unless stated)
//  1. 0x3C00 (1.0) -> int_out=1, ack exactly 13 cycles after acceptance.
//     0x0000 -> 0, ack after 2 cycles.
//  2. 0x3E00 (1.5) -> 1, inexact=1; rnd_mode=1 -> 2.
//     0x4100 (2.5) -> 2 both modes (tie to even).
//     0x3800 (0.5), rnd=1 -> 0. 0x3A00 (0.75), rnd=1 -> 1.
//  3. 0x7700 (28672) -> 28672, sat=0.
//     0x7B80 (61440) -> 32767, sat=1, 2-cycle latency.
//     0x7C00 -> 32767, sat=1.
//     0x7E00 (NaN) -> 32767, sat=1.
//  4. 0xC500 (-5.0) -> 0xFFFB.
//     0xF800 (-32768) -> 0x8000, sat=0.
//     0xFC00 -> 0x8000, sat=1.
//     0xBE00 (-1.5), rnd=1 -> 0xFFFE.
//  5. Pull reset_n low mid-SHIFT on 0x3C00 -> outputs 0 immediately, no ack.
//     Then req 0x4500 -> 5.
//  6. Hold req high over 3 queued values -> each acked once, in order.
//     req pulsed while busy -> ignored, no extra ack.
//     Compare all results against a real-number model with the same clamp.

Source files
------------

// File: rtl/flt2int_iter_if.sv
`default_nettype none
// ============================================================================
//  Module   : flt2int_iter_if
//  Purpose  : Request/acknowledge bus between a datapath (master) and the
//             iterative float-to-integer coprocessor (slave).
//  Signals  : req      - conversion request (master -> slave)
//             rnd_mode - 0 truncate, 1 round-nearest-even (master -> slave)
//             flt_in   - {sign, exponent, fraction} operand (master -> slave)
//             busy     - conversion in progress (slave -> master)
//             ack      - one-cycle result-valid pulse (slave -> master)
//             int_out  - signed integer result (slave -> master)
//             sat      - result was clamped (slave -> master)
//             inexact  - nonzero fraction bits discarded (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface flt2int_iter_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int INT_W = 16
);
  logic                   req;
  logic                   rnd_mode;
  logic [EXP_W+MAN_W:0]   flt_in;
  logic                   busy;
  logic                   ack;
  logic [INT_W-1:0]       int_out;
  logic                   sat;
  logic                   inexact;

  modport master (
    output req, rnd_mode, flt_in,
    input  busy, ack, int_out, sat, inexact
  );

  modport slave (
    input  req, rnd_mode, flt_in,
    output busy, ack, int_out, sat, inexact
  );
endinterface
`default_nettype wire

// File: rtl/flt2int_iter.sv
`default_nettype none
// ============================================================================
//  Module   : flt2int_iter
//  Purpose  : Iterative IEEE-style float to signed two's-complement integer
//             converter. Shifts the significand one bit per cycle, supports
//             truncation or round-nearest-even, and saturates at both ends.
//  Ports    : clk     - rising-edge clock
//             reset_n - asynchronous active-low reset
//             bus     - flt2int_iter_if slave modport (req/ack handshake,
//                       operand, result and flags)
//  Revision : 1.0 - initial release
// ============================================================================
module flt2int_iter #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int INT_W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  flt2int_iter_if.slave  bus
);

  localparam int BIAS  = 2**(EXP_W-1) - 1;
  localparam int FLT_W = 1 + EXP_W + MAN_W;
  localparam int CNT_W = $clog2(INT_W + MAN_W + 2);
  localparam logic [INT_W-1:0] MAX_POS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN_NEG = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_SHIFT  = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [FLT_W-1:0]   flt_q, flt_d;
  logic               rnd_q, rnd_d;
  logic [INT_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               left_q, left_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic [INT_W-1:0]   int_q, int_d;
  logic               sat_q, sat_d;
  logic               inexact_q, inexact_d;

  // Field decode of the captured operand
  logic               w_sign;
  logic [EXP_W-1:0]   w_exp;
  logic [MAN_W-1:0]   w_frac;
  logic signed [31:0] w_e;
  logic               w_inc;
  logic [INT_W-1:0]   w_rmag;

  assign w_sign = flt_q[FLT_W-1];
  assign w_exp  = flt_q[FLT_W-2 -: EXP_W];
  assign w_frac = flt_q[MAN_W-1:0];
  assign w_e    = $signed({{(32-EXP_W){1'b0}}, w_exp}) - BIAS;

  // Round-nearest-even increment; magnitude is below 2**(INT_W-1) here,
  // so the sum cannot wrap the INT_W-bit register.
  assign w_inc  = rnd_q & guard_q & (sticky_q | mag_q[0]);
  assign w_rmag = mag_q + {{(INT_W-1){1'b0}}, w_inc};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      flt_q     <= '0;
      rnd_q     <= 1'b0;
      mag_q     <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      int_q     <= '0;
      sat_q     <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flt_q     <= flt_d;
      rnd_q     <= rnd_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      int_q     <= int_d;
      sat_q     <= sat_d;
      inexact_q <= inexact_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    flt_d     = flt_q;
    rnd_d     = rnd_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    int_d     = int_q;
    sat_d     = sat_q;
    inexact_d = inexact_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          flt_d   = bus.flt_in;
          rnd_d   = bus.rnd_mode;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        mag_d    = {{(INT_W-MAN_W-1){1'b0}}, |w_exp, w_frac};
        if (w_exp == '0) begin
          // zero or subnormal: magnitude is far below one half
          int_d     = '0;
          sat_d     = 1'b0;
          inexact_d = |w_frac;
          state_d   = S_DONE;
        end else if (&w_exp) begin
          // only exact -inf maps to MIN; NaN of either sign maps to MAX
          int_d     = (w_sign && (w_frac == '0)) ? MIN_NEG : MAX_POS;
          sat_d     = 1'b1;
          inexact_d = 1'b0;
          state_d   = S_DONE;
        end else if (w_e < -1) begin
          int_d     = '0;
          sat_d     = 1'b0;
          inexact_d = 1'b1;
          state_d   = S_DONE;
        end else if (w_e >= INT_W-1) begin
          int_d     = w_sign ? MIN_NEG : MAX_POS;
          // exactly -2**(INT_W-1) is representable
          sat_d     = !(w_sign && (w_e == INT_W-1) && (w_frac == '0));
          inexact_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          if (w_e >= MAN_W) begin
            left_d = 1'b1;
            cnt_d  = CNT_W'(w_e - MAN_W);
          end else begin
            left_d = 1'b0;
            cnt_d  = CNT_W'(MAN_W - w_e);
          end
          state_d = (w_e == MAN_W) ? S_ROUND : S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d    = mag_q >> 1;
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        inexact_d = guard_q | sticky_q;
        if (!w_sign) begin
          if (w_rmag > MAX_POS) begin
            int_d = MAX_POS;
            sat_d = 1'b1;
          end else begin
            int_d = w_rmag;
            sat_d = 1'b0;
          end
        end else begin
          if (w_rmag > MIN_NEG) begin
            int_d = MIN_NEG;
            sat_d = 1'b1;
          end else begin
            int_d = '0 - w_rmag;
            sat_d = 1'b0;
          end
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.ack     = (state_q == S_DONE);
  assign bus.int_out = int_q;
  assign bus.sat     = sat_q;
  assign bus.inexact = inexact_q;

endmodule
`default_nettype wire

// File: tb/tb_flt2int_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flt2int_iter
//  Purpose  : Self-checking bench for flt2int_iter (half-precision defaults).
//             Expected results come from a real-number model of the
//             conversion rules plus directed constants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flt2int_iter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  flt2int_iter_if #(.EXP_W(5), .MAN_W(10), .INT_W(16)) bus ();

  flt2int_iter #(.EXP_W(5), .MAN_W(10), .INT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value of the half-precision pattern as a real number,
  // truncated or rounded to nearest-even, then clamped to 16-bit signed.
  function automatic void model(input logic [15:0] f, input bit rnd,
                                output int res, output bit s, output bit ix,
                                output int lat);
    bit   sgn;
    int   ex, fr, p, ival, e;
    real  mag, fl, fp;
    sgn = f[15];
    ex  = int'(f[14:10]);
    fr  = int'(f[9:0]);
    e   = ex - 15;
    if (ex == 0 || ex == 31 || e < -1 || e >= 15) lat = 2;
    else lat = 3 + ((e >= 10) ? (e - 10) : (10 - e));
    if (ex == 31) begin
      res = (sgn && fr == 0) ? -32768 : 32767;
      s   = 1'b1;
      ix  = 1'b0;
      return;
    end
    if (ex == 0) begin
      mag = real'(fr);
      p   = -24;
    end else begin
      mag = 1024.0 + real'(fr);
      p   = ex - 25;
    end
    for (int i = 0; i < p; i++) mag = mag * 2.0;
    for (int i = 0; i < -p; i++) mag = mag / 2.0;
    fl   = $floor(mag);
    fp   = mag - fl;
    ix   = (fp != 0.0);
    ival = $rtoi(fl);
    if (rnd && (fp > 0.5 || (fp == 0.5 && (ival % 2) == 1))) ival = ival + 1;
    res = sgn ? -ival : ival;
    s   = 1'b0;
    if (res > 32767) begin
      res = 32767;
      s   = 1'b1;
    end else if (res < -32768) begin
      res = -32768;
      s   = 1'b1;
    end
  endfunction

  // Issue one request from an IDLE cycle (called at posedge+1) and wait for ack.
  // lat is the index of the ack cycle counting the cycle after acceptance as 1.
  task automatic convert(input logic [15:0] f, input bit rnd,
                         output logic [15:0] res, output bit s, output bit ix,
                         output int lat);
    bus.req      = 1'b1;
    bus.flt_in   = f;
    bus.rnd_mode = rnd;
    @(posedge clk); #1;
    bus.req      = 1'b0;
    bus.flt_in   = 16'($urandom);
    bus.rnd_mode = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (bus.ack === 1'b1) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    res = bus.int_out;
    s   = bus.sat;
    ix  = bus.inexact;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.busy, bus.ack, bus.sat, bus.inexact} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/ack/sat/inexact=%b required 0000",
               {bus.busy, bus.ack, bus.sat, bus.inexact});
    end
    n_checks++;
    if (bus.int_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_int_out: got %h required 0000", bus.int_out);
    end
  endtask

  typedef struct {
    logic [15:0] f;
    bit          r;
    logic [15:0] v;
    bit          s;
  } vec_t;

  task automatic test_directed();
    vec_t        tbl[$];
    logic [15:0] res;
    bit          s, ix, mix, ms;
    int          lat, mres, mlat;
    tbl.push_back('{16'h3C00, 1'b0, 16'h0001, 1'b0});
    tbl.push_back('{16'h0000, 1'b0, 16'h0000, 1'b0});
    tbl.push_back('{16'h3E00, 1'b0, 16'h0001, 1'b0});
    tbl.push_back('{16'h3E00, 1'b1, 16'h0002, 1'b0});
    tbl.push_back('{16'h4100, 1'b0, 16'h0002, 1'b0});
    tbl.push_back('{16'h4100, 1'b1, 16'h0002, 1'b0});
    tbl.push_back('{16'h3800, 1'b1, 16'h0000, 1'b0});
    tbl.push_back('{16'h3A00, 1'b1, 16'h0001, 1'b0});
    tbl.push_back('{16'h7700, 1'b0, 16'd28672, 1'b0});
    tbl.push_back('{16'h7B80, 1'b0, 16'h7FFF, 1'b1});
    tbl.push_back('{16'h7C00, 1'b0, 16'h7FFF, 1'b1});
    tbl.push_back('{16'h7E00, 1'b0, 16'h7FFF, 1'b1});
    tbl.push_back('{16'hC500, 1'b0, 16'hFFFB, 1'b0});
    tbl.push_back('{16'hF800, 1'b0, 16'h8000, 1'b0});
    tbl.push_back('{16'hFC00, 1'b0, 16'h8000, 1'b1});
    tbl.push_back('{16'hBE00, 1'b1, 16'hFFFE, 1'b0});
    tbl.push_back('{16'h8000, 1'b0, 16'h0000, 1'b0});
    tbl.push_back('{16'h3BFF, 1'b1, 16'h0001, 1'b0});
    foreach (tbl[i]) begin
      convert(tbl[i].f, tbl[i].r, res, s, ix, lat);
      model(tbl[i].f, tbl[i].r, mres, ms, mix, mlat);
      n_checks++;
      if (res !== tbl[i].v || s !== tbl[i].s) begin
        n_fail++;
        $display("FAIL directed_%h_r%0d: int=%h sat=%0d required int=%h sat=%0d",
                 tbl[i].f, tbl[i].r, res, s, tbl[i].v, tbl[i].s);
      end
      n_checks++;
      if (ix !== mix) begin
        n_fail++;
        $display("FAIL directed_inexact_%h: got %0d required %0d", tbl[i].f, ix, mix);
      end
      n_checks++;
      if (lat !== mlat) begin
        n_fail++;
        $display("FAIL directed_latency_%h: got %0d required %0d", tbl[i].f, lat, mlat);
      end
    end
    // the first two are the headline latencies; check them against constants too
    convert(16'h3C00, 1'b0, res, s, ix, lat);
    n_checks++;
    if (lat !== 13) begin
      n_fail++;
      $display("FAIL latency_one: got %0d required 13", lat);
    end
    convert(16'h0000, 1'b0, res, s, ix, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL latency_zero: got %0d required 2", lat);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ack !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_ack: busy=%0d ack=%0d required 0 0", bus.busy, bus.ack);
    end
  endtask

  task automatic test_random();
    logic [15:0] f, res;
    bit          r, s, ix, ms, mix;
    int          lat, mres, mlat;
    for (int n = 0; n < 200; n++) begin
      f = 16'($urandom);
      // steer most samples into the non-special exponent range
      if (n % 4 != 0) f[14:10] = 5'($urandom_range(14, 29));
      r = 1'($urandom);
      convert(f, r, res, s, ix, lat);
      model(f, r, mres, ms, mix, mlat);
      n_checks++;
      if (res !== 16'(mres) || s !== ms || ix !== mix || lat !== mlat) begin
        n_fail++;
        $display("FAIL random_%h_r%0d: int=%h sat=%0d inx=%0d lat=%0d required int=%h sat=%0d inx=%0d lat=%0d",
                 f, r, res, s, ix, lat, 16'(mres), ms, mix, mlat);
      end
    end
  endtask

  task automatic test_reset_midshift();
    logic [15:0] res;
    bit          s, ix;
    int          lat, acks;
    convert(16'h4500, 1'b0, res, s, ix, lat);
    bus.req    = 1'b1;
    bus.flt_in = 16'h3C00;
    bus.rnd_mode = 1'b0;
    @(posedge clk); #1;
    bus.req = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.ack, bus.sat, bus.inexact} !== 4'b0000 || bus.int_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: busy=%0d ack=%0d int=%h sat=%0d inx=%0d required all 0",
               bus.busy, bus.ack, bus.int_out, bus.sat, bus.inexact);
    end
    @(negedge clk);
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL abandoned_ack: got %0d acks required 0", acks);
    end
    convert(16'h4500, 1'b0, res, s, ix, lat);
    n_checks++;
    if (res !== 16'h0005 || s !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: int=%h sat=%0d required 0005 0", res, s);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v[3];
    int          mres, mlat, idx, next_ack, extra;
    bit          ms, mix;
    v[0] = 16'h4500;
    v[1] = 16'hBE00;
    v[2] = 16'($urandom_range(16'h3800, 16'h7000));
    idx = 0;
    bus.rnd_mode = 1'b1;
    bus.flt_in   = v[0];
    bus.req      = 1'b1;
    @(posedge clk); #1;
    bus.flt_in = 16'($urandom);
    model(v[0], 1'b1, mres, ms, mix, mlat);
    next_ack = mlat;
    for (int c = 1; c <= 150 && idx < 3; c++) begin
      if (bus.ack === 1'b1) begin
        model(v[idx], 1'b1, mres, ms, mix, mlat);
        n_checks++;
        if (bus.int_out !== 16'(mres) || bus.sat !== ms || c !== next_ack) begin
          n_fail++;
          $display("FAIL back_to_back_%0d: int=%h sat=%0d cycle=%0d required int=%h sat=%0d cycle=%0d",
                   idx, bus.int_out, bus.sat, c, 16'(mres), ms, next_ack);
        end
        idx++;
        if (idx < 3) begin
          bus.flt_in = v[idx];
          model(v[idx], 1'b1, mres, ms, mix, mlat);
          next_ack = c + mlat + 1;
        end else begin
          bus.req = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    bus.req = 1'b0;
    n_checks++;
    if (idx !== 3) begin
      n_fail++;
      $display("FAIL back_to_back_count: got %0d acks required 3", idx);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.ack === 1'b1) extra++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL back_to_back_extra: got %0d acks required 0", extra);
    end
  endtask

  task automatic test_req_while_busy();
    int          acks;
    logic [15:0] last;
    bus.rnd_mode = 1'b0;
    bus.flt_in   = 16'h4100;
    bus.req      = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.req    = 1'b1;
    bus.flt_in = 16'h7700;
    @(posedge clk); #1;
    bus.req = 1'b0;
    acks = 0;
    last = 16'hDEAD;
    for (int i = 0; i < 30; i++) begin
      if (bus.ack === 1'b1) begin
        acks++;
        last = bus.int_out;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (acks !== 1 || last !== 16'h0002) begin
      n_fail++;
      $display("FAIL req_while_busy: acks=%0d int=%h required 1 0002", acks, last);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    bus.req      = 1'b0;
    bus.rnd_mode = 1'b0;
    bus.flt_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_reset_midshift();
    test_back_to_back();
    test_req_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
